// File: rtl/dmem_access_controller.sv
// dmem_access_controller
// Multi-cycle load/store sequencer between the MEM stage and a word-organised
// data memory. It latches one request, stalls the pipeline with Busy, runs a
// byte-enabled request/ready handshake, and returns RV32 extended load data.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are trapped. When it is undefined, the low address bits
// are ignored and the access proceeds normally.

module dmem_access_controller #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [31:0]           Address,
  input  logic [31:0]           Write_data,
  input  logic [2:0]            Func3,
  output logic [31:0]           Read_data,
  output logic                  Busy,
  output logic                  Misaligned,
  output logic                  Mem_Read,
  output logic                  Mem_Write,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [31:0]           Mem_Write_data,
  output logic [3:0]            Mem_Byte_en,
  input  logic [31:0]           Mem_Read_data,
  input  logic                  Mem_Ready
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [2:0]            func3_q;
  logic                  is_load_q;
  logic                  trap_q;

  logic                  request;
  logic                  legal;
  logic                  misaligned_req;
  logic [3:0]            store_be;
  logic [31:0]           store_data;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [31:0]           load_value;
  logic                  unused_addr;

  // Address bits above the memory word range never reach the memory.
  assign unused_addr = ^Address[31:ADDR_WIDTH+2];

  assign request     = Read | Write;
  assign Mem_Address = addr_q[ADDR_WIDTH+1:2];
  assign Misaligned  = trap_q;

  // Busy also covers the IDLE cycle that accepts the request, so the stage stalls at once.
  assign Busy = (state == REQ) || ((state == IDLE) && request);

  // Check that funct3 is legal for the operation kind. Write overrides Read.
  always_comb begin
    legal = 1'b0;
    if (Write)
      legal = (Func3 == 3'b000) || (Func3 == 3'b001) || (Func3 == 3'b010);
    else
      legal = (Func3 == 3'b000) || (Func3 == 3'b001) || (Func3 == 3'b010) ||
              (Func3 == 3'b100) || (Func3 == 3'b101);
  end

`ifdef MISALIGN_TRAP_EN
  // Detect a halfword on an odd address, or a word that is not on a 4-byte boundary.
  always_comb begin
    misaligned_req = ((Func3[1:0] == 2'b01) && Address[0]) ||
                     ((Func3[1:0] == 2'b10) && (Address[1:0] != 2'b00));
  end
`else
  // Misaligned accesses are forced down to alignment and are never trapped.
  always_comb begin
    misaligned_req = 1'b0;
  end
`endif

  // Place store data on its byte lanes and replicate narrow data across the word.
  always_comb begin
    store_be   = 4'b0000;
    store_data = Write_data;
    case (Func3[1:0])
      2'b00: begin
        store_be   = 4'b0001 << Address[1:0];
        store_data = {4{Write_data[7:0]}};
      end
      2'b01: begin
        store_be   = Address[1] ? 4'b1100 : 4'b0011;
        store_data = {2{Write_data[15:0]}};
      end
      default: store_be = 4'b1111;
    endcase
  end

  // Select the addressed byte or half of the returned word, then extend it as funct3 requests.
  always_comb begin
    load_byte  = 8'h00;
    load_half  = addr_q[1] ? Mem_Read_data[31:16] : Mem_Read_data[15:0];
    load_value = 32'h0;
    case (addr_q[1:0])
      2'b00:   load_byte = Mem_Read_data[7:0];
      2'b01:   load_byte = Mem_Read_data[15:8];
      2'b10:   load_byte = Mem_Read_data[23:16];
      default: load_byte = Mem_Read_data[31:24];
    endcase
    case (func3_q)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b010:  load_value = Mem_Read_data;
      3'b100:  load_value = {24'h0, load_byte};
      3'b101:  load_value = {16'h0, load_half};
      default: load_value = 32'h0;
    endcase
  end

  // Sequencer: accept a request, hold the memory request until ready, then spend one DONE cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      addr_q         <= '0;
      func3_q        <= 3'b000;
      is_load_q      <= 1'b0;
      trap_q         <= 1'b0;
      Read_data      <= 32'h0;
      Mem_Read       <= 1'b0;
      Mem_Write      <= 1'b0;
      Mem_Write_data <= 32'h0;
      Mem_Byte_en    <= 4'b0000;
    end else begin
      trap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            addr_q    <= Address[ADDR_WIDTH+1:0];
            func3_q   <= Func3;
            is_load_q <= ~Write;
            if (!legal) begin
              state <= DONE;
              if (!Write)
                Read_data <= 32'h0;
            end else if (misaligned_req) begin
              state  <= DONE;
              trap_q <= 1'b1;
            end else begin
              state     <= REQ;
              Mem_Read  <= ~Write;
              Mem_Write <= Write;
              if (Write) begin
                Mem_Byte_en    <= store_be;
                Mem_Write_data <= store_data;
              end
            end
          end
        end
        REQ: begin
          if (Mem_Ready) begin
            state       <= DONE;
            Mem_Read    <= 1'b0;
            Mem_Write   <= 1'b0;
            Mem_Byte_en <= 4'b0000;
            if (is_load_q)
              Read_data <= load_value;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_controller.sv
// tb_dmem_access_controller
// Directed bench for dmem_access_controller. The misaligned-access checks follow
// whether MISALIGN_TRAP_EN is defined for the build.

module tb_dmem_access_controller;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Read, Write;
  logic [31:0] Address, Write_data;
  logic [2:0]  Func3;
  logic [31:0] Read_data;
  logic        Busy, Misaligned, Mem_Read, Mem_Write;
  logic [9:0]  Mem_Address;
  logic [31:0] Mem_Write_data;
  logic [3:0]  Mem_Byte_en;
  logic [31:0] Mem_Read_data;
  logic        Mem_Ready;

  int errors = 0;
  int checks = 0;

  int          busy_cnt;
  logic        timed_out;
  logic        any_read, any_write, any_mis;
  logic        snap_read, snap_write;
  logic [9:0]  snap_addr;
  logic [3:0]  snap_be;
  logic [31:0] snap_wdata;
  logic        done_busy, done_read, done_write, done_mis, after_mis;

  dmem_access_controller #(.ADDR_WIDTH(10)) dut (
    .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write),
    .Address(Address), .Write_data(Write_data), .Func3(Func3),
    .Read_data(Read_data), .Busy(Busy), .Misaligned(Misaligned),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Address(Mem_Address),
    .Mem_Write_data(Mem_Write_data), .Mem_Byte_en(Mem_Byte_en),
    .Mem_Read_data(Mem_Read_data), .Mem_Ready(Mem_Ready)
  );

  always #5 Clock = ~Clock;

  // Run one operation from an IDLE negedge. Record what is seen in the first
  // REQ cycle and in the DONE cycle. Mem_Ready is raised in REQ cycle number 'delay'.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] mword, input int delay);
    int cyc;
    Read = rd; Write = wr; Address = addr; Write_data = wd; Func3 = f3;
    Mem_Read_data = mword; Mem_Ready = 1'b0;
    busy_cnt = 0; timed_out = 1'b0;
    any_read = 1'b0; any_write = 1'b0; any_mis = 1'b0;
    snap_read = 1'b0; snap_write = 1'b0; snap_addr = '0; snap_be = '0; snap_wdata = '0;
    #1;
    if (Busy) busy_cnt++;
    any_read |= Mem_Read; any_write |= Mem_Write; any_mis |= Misaligned;
    @(negedge Clock);
    Read = 1'b0; Write = 1'b0;
    cyc = 0;
    while (Busy && cyc < 200) begin
      if (cyc == 0) begin
        snap_read = Mem_Read; snap_write = Mem_Write; snap_addr = Mem_Address;
        snap_be = Mem_Byte_en; snap_wdata = Mem_Write_data;
      end
      any_read |= Mem_Read; any_write |= Mem_Write; any_mis |= Misaligned;
      busy_cnt++;
      Mem_Ready = (cyc >= delay);
      @(negedge Clock);
      Mem_Ready = 1'b0;
      cyc++;
    end
    if (cyc >= 200) timed_out = 1'b1;
    done_busy = Busy; done_read = Mem_Read; done_write = Mem_Write; done_mis = Misaligned;
    any_read |= Mem_Read; any_write |= Mem_Write;
    @(negedge Clock);
    after_mis = Misaligned;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Read = 1'b0; Write = 1'b0; Address = '0; Write_data = '0;
    Func3 = '0; Mem_Read_data = '0; Mem_Ready = 1'b0;
    @(negedge Clock); @(negedge Clock);
    checks++;
    if ({Busy, Mem_Read, Mem_Write, Misaligned, Mem_Byte_en} !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected 00000000", {Busy, Mem_Read, Mem_Write, Misaligned, Mem_Byte_en});
    end
    checks++;
    if (Read_data !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_read_data: got %h expected 00000000", Read_data);
    end
    Reset = 1'b0;
    @(negedge Clock);
    run_op(1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 32'h12345678, 0);
    checks++;
    if (Read_data !== 32'h12345678) begin
      errors++; $display("[TB] FAIL reset_pre_load: got %h expected 12345678", Read_data);
    end
    Read = 1'b1; Address = 32'h4; Func3 = 3'b010; Mem_Ready = 1'b0;
    @(negedge Clock);
    Read = 1'b0;
    checks++;
    if (Mem_Read !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_req_pending: got %b expected 1", Mem_Read);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (Mem_Read !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_async_strobe: got %b expected 0", Mem_Read);
    end
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy_after: got %b expected 0", Busy);
    end
    checks++;
    if (Read_data !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_read_data_after: got %h expected 00000000", Read_data);
    end
    @(negedge Clock);
  endtask

  task automatic test_sw();
    run_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
    checks++;
    if (snap_addr !== 10'd4) begin
      errors++; $display("[TB] FAIL sw_addr: got %0d expected 4", snap_addr);
    end
    checks++;
    if (snap_be !== 4'b1111) begin
      errors++; $display("[TB] FAIL sw_byte_en: got %b expected 1111", snap_be);
    end
    checks++;
    if (snap_wdata !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL sw_data: got %h expected deadbeef", snap_wdata);
    end
    checks++;
    if ({snap_write, snap_read} !== 2'b10) begin
      errors++; $display("[TB] FAIL sw_strobes: got %b expected 10", {snap_write, snap_read});
    end
    checks++;
    if (busy_cnt !== 2 || timed_out) begin
      errors++; $display("[TB] FAIL sw_busy_len: got %0d expected 2 (timeout %b)", busy_cnt, timed_out);
    end
    checks++;
    if ({done_busy, done_write, done_read} !== 3'b000) begin
      errors++; $display("[TB] FAIL sw_done_cycle: got %b expected 000", {done_busy, done_write, done_read});
    end
  endtask

  task automatic test_sb_lb();
    run_op(1'b0, 1'b1, 32'h13, 32'h000000A5, 3'b000, 32'h0, 0);
    checks++;
    if (snap_be !== 4'b1000) begin
      errors++; $display("[TB] FAIL sb_byte_en: got %b expected 1000", snap_be);
    end
    checks++;
    if (snap_wdata !== 32'hA5A5A5A5) begin
      errors++; $display("[TB] FAIL sb_data: got %h expected a5a5a5a5", snap_wdata);
    end
    run_op(1'b1, 1'b0, 32'h13, 32'h0, 3'b000, 32'hA5000000, 0);
    checks++;
    if (Read_data !== 32'hFFFFFFA5) begin
      errors++; $display("[TB] FAIL lb_sign: got %h expected ffffffa5", Read_data);
    end
    checks++;
    if ({snap_read, snap_write, snap_be} !== 6'b100000) begin
      errors++; $display("[TB] FAIL lb_strobes: got %b expected 100000", {snap_read, snap_write, snap_be});
    end
    run_op(1'b1, 1'b0, 32'h13, 32'h0, 3'b100, 32'hA5000000, 0);
    checks++;
    if (Read_data !== 32'h000000A5) begin
      errors++; $display("[TB] FAIL lbu_zero: got %h expected 000000a5", Read_data);
    end
    run_op(1'b0, 1'b1, 32'h22, 32'h1234BEEF, 3'b001, 32'h0, 0);
    checks++;
    if ({snap_be, snap_wdata} !== {4'b1100, 32'hBEEFBEEF}) begin
      errors++; $display("[TB] FAIL sh_lanes: got %b %h expected 1100 beefbeef", snap_be, snap_wdata);
    end
    checks++;
    if (Read_data !== 32'h000000A5) begin
      errors++; $display("[TB] FAIL store_keeps_read_data: got %h expected 000000a5", Read_data);
    end
  endtask

  task automatic test_lh();
    run_op(1'b1, 1'b0, 32'h22, 32'h0, 3'b001, 32'h80011234, 4);
    checks++;
    if (busy_cnt !== 6 || timed_out) begin
      errors++; $display("[TB] FAIL lh_busy_len: got %0d expected 6 (timeout %b)", busy_cnt, timed_out);
    end
    checks++;
    if (Read_data !== 32'hFFFF8001) begin
      errors++; $display("[TB] FAIL lh_sign: got %h expected ffff8001", Read_data);
    end
    checks++;
    if (snap_addr !== 10'd8) begin
      errors++; $display("[TB] FAIL lh_addr: got %0d expected 8", snap_addr);
    end
    run_op(1'b1, 1'b0, 32'h22, 32'h0, 3'b101, 32'h80011234, 0);
    checks++;
    if (Read_data !== 32'h00008001) begin
      errors++; $display("[TB] FAIL lhu_zero: got %h expected 00008001", Read_data);
    end
    run_op(1'b1, 1'b0, 32'h20, 32'h0, 3'b001, 32'h80011234, 0);
    checks++;
    if (Read_data !== 32'h00001234) begin
      errors++; $display("[TB] FAIL lh_low_half: got %h expected 00001234", Read_data);
    end
  endtask

  task automatic test_conflict_illegal();
    run_op(1'b1, 1'b1, 32'h40, 32'h55AA55AA, 3'b010, 32'h0, 0);
    checks++;
    if ({snap_write, snap_read, any_read} !== 3'b100) begin
      errors++; $display("[TB] FAIL rw_write_wins: got %b expected 100", {snap_write, snap_read, any_read});
    end
    run_op(1'b0, 1'b1, 32'h40, 32'h11111111, 3'b011, 32'h0, 0);
    checks++;
    if (busy_cnt !== 1 || any_write !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_store: got busy %0d write %b expected busy 1 write 0", busy_cnt, any_write);
    end
    checks++;
    if (Read_data !== 32'h00001234) begin
      errors++; $display("[TB] FAIL illegal_store_read_data: got %h expected 00001234", Read_data);
    end
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 3'b011, 32'hFFFFFFFF, 0);
    checks++;
    if (busy_cnt !== 1 || any_read !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_load: got busy %0d read %b expected busy 1 read 0", busy_cnt, any_read);
    end
    checks++;
    if (Read_data !== 32'h0) begin
      errors++; $display("[TB] FAIL illegal_load_data: got %h expected 00000000", Read_data);
    end
  endtask

  task automatic test_misalign();
    run_op(1'b1, 1'b0, 32'h08, 32'h0, 3'b010, 32'h11112222, 0);
    checks++;
    if (Read_data !== 32'h11112222 || any_mis !== 1'b0) begin
      errors++; $display("[TB] FAIL aligned_lw: got %h mis %b expected 11112222 mis 0", Read_data, any_mis);
    end
    run_op(1'b1, 1'b0, 32'h06, 32'h0, 3'b010, 32'hCAFEF00D, 0);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (busy_cnt !== 1 || any_read !== 1'b0) begin
      errors++; $display("[TB] FAIL mis_no_access: got busy %0d read %b expected busy 1 read 0", busy_cnt, any_read);
    end
    checks++;
    if ({done_mis, after_mis} !== 2'b10) begin
      errors++; $display("[TB] FAIL mis_flag_pulse: got %b expected 10", {done_mis, after_mis});
    end
    checks++;
    if (Read_data !== 32'h11112222) begin
      errors++; $display("[TB] FAIL mis_read_data_kept: got %h expected 11112222", Read_data);
    end
`else
    checks++;
    if (snap_read !== 1'b1 || snap_addr !== 10'd1) begin
      errors++; $display("[TB] FAIL mis_forced_align: got read %b addr %0d expected read 1 addr 1", snap_read, snap_addr);
    end
    checks++;
    if ({any_mis, done_mis, after_mis} !== 3'b000) begin
      errors++; $display("[TB] FAIL mis_flag_tied: got %b expected 000", {any_mis, done_mis, after_mis});
    end
    checks++;
    if (Read_data !== 32'hCAFEF00D) begin
      errors++; $display("[TB] FAIL mis_forced_data: got %h expected cafef00d", Read_data);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_lb();
    test_lh();
    test_conflict_illegal();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
